// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a requester and the apb_slave_mem completer.
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register file; out-of-range words answer PSLVERR.
// Define APB_WAIT_STATE_EN to insert one wait state into every transfer (default: zero wait states).
module apb_slave_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32
) (
    input  logic           pclk,
    input  logic           prst,
    apb_slave_mem_if.slave bus
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_r;
    state_t                phase_s;
    logic                  done_r;
    logic                  wait_ok_s;
    logic                  err_s;
    logic                  pready_s;
    logic                  commit_s;
    logic [IDX_W-1:0]      idx_s;
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // Phase of the current bus cycle: state_r is last cycle's phase, done_r says it completed.
    always_comb begin
        phase_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.psel && !bus.penable) phase_s = SETUP;
                else                          phase_s = IDLE;
            end
            SETUP: begin
                if (!bus.psel)        phase_s = IDLE;
                else if (bus.penable) phase_s = ACCESS;
                else                  phase_s = SETUP;
            end
            ACCESS: begin
                if (!done_r)                       phase_s = ACCESS;
                else if (bus.psel && !bus.penable) phase_s = SETUP;
                else                               phase_s = IDLE;
            end
            default: phase_s = IDLE;
        endcase
    end

`ifdef APB_WAIT_STATE_EN
    logic waited_r;

    // Marks that the first ACCESS cycle of the current transfer has already been spent waiting.
    always_ff @(posedge pclk) begin
        if (prst) begin
            waited_r <= 1'b0;
        end else begin
            waited_r <= (phase_s == ACCESS) && !waited_r;
        end
    end

    assign wait_ok_s = waited_r;
`else
    assign wait_ok_s = 1'b1;
`endif

    assign err_s    = (32'(bus.paddr) >= 32'(MEM_DEPTH));
    assign idx_s    = bus.paddr[IDX_W-1:0];
    assign pready_s = (phase_s == ACCESS) && wait_ok_s && !prst;
    assign commit_s = pready_s && bus.pwrite && !err_s;

    assign bus.pready  = pready_s;
    assign bus.pslverr = pready_s && err_s;
    assign bus.prdata  = (pready_s && !bus.pwrite && !err_s) ? mem_r[idx_s] : {DATA_WIDTH{1'b0}};

    // Phase tracking and memory; reset clears every word so post-reset reads return zero.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_r <= phase_s;
            done_r  <= pready_s;
            if (commit_s) begin
                mem_r[idx_s] <= bus.pwdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed table, back-to-back fill, reset abort, random traffic.
module tb_apb_slave_mem;
    localparam int DEPTH = 32;
`ifdef APB_WAIT_STATE_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    logic pclk = 1'b0;
    logic prst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model_mem [DEPTH];

    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_if ();

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus_if)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete transfer; starts and ends just after a rising edge, leaves idle cycles behind it.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input int idle,
                        output logic [31:0] rd, output logic er);
        int acc;
        bit got;
        bus_if.psel    = 1'b1;
        bus_if.penable = 1'b0;
        bus_if.pwrite  = w;
        bus_if.paddr   = a;
        bus_if.pwdata  = d;
        @(negedge pclk);
        chk("setup_pready", {31'd0, bus_if.pready}, 32'd0);
        @(posedge pclk); #1;
        bus_if.penable = 1'b1;
        acc = 0;
        got = 1'b0;
        rd  = 32'd0;
        er  = 1'b0;
        while (!got && acc < 8) begin
            @(negedge pclk);
            acc++;
            if (bus_if.pready) begin
                got = 1'b1;
                rd  = bus_if.prdata;
                er  = bus_if.pslverr;
            end
            @(posedge pclk); #1;
        end
        chk("access_cycles", 32'(acc), 32'(EXP_ACC));
        bus_if.psel    = 1'b0;
        bus_if.penable = 1'b0;
        repeat (idle) begin
            @(posedge pclk); #1;
        end
    endtask

    // Reference: in-range writes update the array, reads return it, out-of-range is error with zero data.
    task automatic model_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] erd, output logic eerr);
        eerr = (int'(a) >= DEPTH);
        erd  = 32'd0;
        if (!eerr && w) model_mem[int'(a)] = d;
        if (!eerr && !w) erd = model_mem[int'(a)];
    endtask

    task automatic checked_xfer(input string nm, input logic w, input logic [7:0] a,
                                input logic [31:0] d, input int idle);
        logic [31:0] rd, erd;
        logic        er, eerr;
        model_xfer(w, a, d, erd, eerr);
        xfer(w, a, d, idle, rd, er);
        chk({nm, "_prdata"}, rd, erd);
        chk({nm, "_pslverr"}, {31'd0, er}, {31'd0, eerr});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        vecs[0]  = '{1'b1, 8'd5,   32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 8'd5,   32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 8'd40,  32'h12345678, 32'h00000000, 1'b1};
        vecs[3]  = '{1'b0, 8'd40,  32'h00000000, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b0, 8'd0,   32'h00000000, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b1, 8'd31,  32'hCAFEF00D, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 8'd31,  32'h00000000, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{1'b1, 8'd32,  32'h11111111, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, 8'd32,  32'h00000000, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 8'd255, 32'h00000000, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 8'd6,   32'h00000000, 32'h00000000, 1'b0};
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;

        // Reset with a bogus access on the bus: outputs must stay zero.
        bus_if.psel    = 1'b1;
        bus_if.penable = 1'b1;
        bus_if.pwrite  = 1'b0;
        bus_if.paddr   = 8'd0;
        bus_if.pwdata  = 32'd0;
        repeat (3) begin
            @(negedge pclk);
            chk("reset_outputs", {bus_if.prdata[31:2], bus_if.pready, bus_if.pslverr} |
                                 {30'd0, bus_if.prdata[1:0]}, 32'd0);
        end
        @(posedge pclk); #1;
        prst = 1'b0;
        bus_if.psel    = 1'b0;
        bus_if.penable = 1'b0;
        @(posedge pclk); #1;

        for (int i = 0; i < 11; i++) begin
            model_xfer(vecs[i].w, vecs[i].a, vecs[i].d, rd, er);
            xfer(vecs[i].w, vecs[i].a, vecs[i].d, 1, rd, er);
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].erd);
            chk($sformatf("vec%0d_pslverr", i), {31'd0, er}, {31'd0, vecs[i].eerr});
        end

        // Out-of-range writes above must not have touched any legal word.
        for (int i = 0; i < DEPTH; i++) checked_xfer("sweep", 1'b0, 8'(i), 32'd0, 0);

        // Back-to-back fill and readback with no idle cycles between transfers.
        for (int i = 0; i < DEPTH; i++) checked_xfer("fill", 1'b1, 8'(i), 32'(i * 3), 0);
        for (int i = 0; i < DEPTH; i++) checked_xfer("readback", 1'b0, 8'(i), 32'd0, 0);

        // penable without a prior setup phase is ignored.
        @(posedge pclk); #1;
        bus_if.psel    = 1'b1;
        bus_if.penable = 1'b1;
        bus_if.pwrite  = 1'b1;
        bus_if.paddr   = 8'd5;
        bus_if.pwdata  = 32'hFFFFFFFF;
        repeat (3) begin
            @(negedge pclk);
            chk("illegal_pready", {31'd0, bus_if.pready}, 32'd0);
            @(posedge pclk); #1;
        end
        bus_if.psel    = 1'b0;
        bus_if.penable = 1'b0;
        @(posedge pclk); #1;
        checked_xfer("illegal_mem", 1'b0, 8'd5, 32'd0, 0);

        for (int i = 0; i < 150; i++) begin
            checked_xfer("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 47)),
                         $urandom, $urandom_range(0, 2));
        end

        // Reset asserted during the access phase of a write aborts it and clears memory.
        checked_xfer("pre_rst", 1'b1, 8'd7, 32'hA5A5A5A5, 1);
        bus_if.psel    = 1'b1;
        bus_if.penable = 1'b0;
        bus_if.pwrite  = 1'b1;
        bus_if.paddr   = 8'd8;
        bus_if.pwdata  = 32'h5A5A5A5A;
        @(posedge pclk); #1;
        bus_if.penable = 1'b1;
        prst = 1'b1;
        repeat (15) begin
            @(negedge pclk);
            chk("midrst_outputs", {bus_if.prdata[31:2], bus_if.pready, bus_if.pslverr} |
                                  {30'd0, bus_if.prdata[1:0]}, 32'd0);
            @(posedge pclk); #1;
        end
        prst = 1'b0;
        bus_if.psel    = 1'b0;
        bus_if.penable = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        @(posedge pclk); #1;
        checked_xfer("post_rst7", 1'b0, 8'd7, 32'd0, 0);
        checked_xfer("post_rst8", 1'b0, 8'd8, 32'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
